// File: rtl/scarv_cop_malu_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module  : scarv_cop_malu_seq_pkg
// Purpose : Shared constants for the COP multi-precision ALU sequencer.
//           Holds the instruction class that selects the unit, the subclass
//           opcodes, and the FSM state encoding.
// Ports   : none (package)
// Revision: 1.0  initial release
// ============================================================================
package scarv_cop_malu_seq_pkg;

    // id_class value that routes an instruction to this unit
    localparam logic [2:0] c_MP_CLASS = 3'd2;

    // id_subclass opcodes; every other code is illegal
    localparam logic [3:0] c_SUB_MADD = 4'd0;
    localparam logic [3:0] c_SUB_MSUB = 4'd1;
    localparam logic [3:0] c_SUB_MMUL = 4'd2;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_CALC = 3'd1,
        S_MUL  = 3'd2,
        S_WLO  = 3'd3,
        S_WHI  = 3'd4
    } malu_state_t;

endpackage
`default_nettype wire

// File: rtl/scarv_cop_malu_mulstep.sv
`default_nettype none
// ============================================================================
// Module  : scarv_cop_malu_mulstep
// Purpose : One shift-add multiply step. Multiplies the 32-bit multiplicand
//           by a MUL_BPC-bit slice of the multiplier, shifts the partial
//           product into place and adds it to the running accumulator.
// Ports   : i_acc    [63:0]        running accumulator
//           i_mcand  [31:0]        multiplicand
//           i_slice  [MUL_BPC-1:0] current multiplier bits (LSB-first)
//           i_shamt  [5:0]         bit position of the slice
//           o_acc    [63:0]        updated accumulator
// Revision: 1.0  initial release
// ============================================================================
module scarv_cop_malu_mulstep #(
    parameter int MUL_BPC = 1
) (
    input  logic [63:0]        i_acc,
    input  logic [31:0]        i_mcand,
    input  logic [MUL_BPC-1:0] i_slice,
    input  logic [5:0]         i_shamt,
    output logic [63:0]        o_acc
);

    logic [63:0] w_pp;

    always_comb begin
        // Partial product is at most 32+MUL_BPC bits; computed in 64 bits so
        // the shift cannot lose anything before the add.
        w_pp  = {32'd0, i_mcand} * {{(64-MUL_BPC){1'b0}}, i_slice};
        o_acc = i_acc + (w_pp << i_shamt);
    end

endmodule
`default_nettype wire

// File: rtl/scarv_cop_malu_seq.sv
`default_nettype none
// ============================================================================
// Module  : scarv_cop_malu_seq
// Purpose : Sequencer for the COP multi-precision arithmetic unit. Accepts one
//           MP-class instruction (MADD/MSUB/MMUL), runs the datapath for the
//           required number of cycles and writes the 64-bit result to the CPR
//           pair as low word then high word.
// Ports   : g_clk, g_reset        clock, synchronous active-high reset
//           malu_ivalid/idone     instruction handshake (idone = 1-cycle pulse)
//           malu_rs1/rs2/rs3      source operands, sampled only in IDLE
//           id_class/id_subclass  instruction class / operation select
//           malu_wen/wsel/wdata   CPR write port (wsel 0 = rd, 1 = rd+1)
//           malu_busy             high whenever the FSM is not in IDLE
// Revision: 1.0  initial release
// ============================================================================
module scarv_cop_malu_seq
    import scarv_cop_malu_seq_pkg::*;
#(
    parameter int         MUL_BPC  = 1,          // 1, 2, 4 or 8
    parameter logic [2:0] MP_CLASS = c_MP_CLASS
) (
    input  logic        g_clk,
    input  logic        g_reset,
    input  logic        malu_ivalid,
    output logic        malu_idone,
    input  logic [31:0] malu_rs1,
    input  logic [31:0] malu_rs2,
    input  logic [31:0] malu_rs3,
    input  logic [2:0]  id_class,
    input  logic [3:0]  id_subclass,
    output logic        malu_wen,
    output logic        malu_wsel,
    output logic [31:0] malu_wdata,
    output logic        malu_busy
);

    localparam logic [5:0] c_STEPS = 6'(32 / MUL_BPC);
    localparam logic [5:0] c_BPC   = 6'(MUL_BPC);

    malu_state_t r_state_q, w_state_d;
    logic [31:0] r_rs1_q,   w_rs1_d;
    logic [31:0] r_mplr_q,  w_mplr_d;   // multiplier, shifted right each MUL step
    logic        r_cin_q,   w_cin_d;    // rs3[0], carry/borrow-in for ADD/SUB
    logic [3:0]  r_sub_q,   w_sub_d;
    logic [63:0] r_acc_q,   w_acc_d;
    logic [5:0]  r_cnt_q,   w_cnt_d;
    logic [5:0]  r_shamt_q, w_shamt_d;
    logic        r_idone_q, w_idone_d;
    logic        r_wen_q,   w_wen_d;
    logic        r_wsel_q,  w_wsel_d;
    logic [31:0] r_wdata_q, w_wdata_d;

    logic        w_accept;
    logic [32:0] w_sum;
    logic [32:0] w_diff;
    logic [63:0] w_mul_acc;

    scarv_cop_malu_mulstep #(
        .MUL_BPC (MUL_BPC)
    ) u_mulstep (
        .i_acc   (r_acc_q),
        .i_mcand (r_rs1_q),
        .i_slice (r_mplr_q[MUL_BPC-1:0]),
        .i_shamt (r_shamt_q),
        .o_acc   (w_mul_acc)
    );

    // The decoder holds ivalid until it sees idone, so ivalid is still high
    // in the idone cycle; blocking acceptance then prevents a re-issue.
    assign w_accept = malu_ivalid && (id_class == MP_CLASS) && !r_idone_q;

    // 33-bit results: bit 32 is the carry (ADD) or borrow (SUB) out.
    assign w_sum  = {1'b0, r_rs1_q} + {1'b0, r_mplr_q} + {32'd0, r_cin_q};
    assign w_diff = {1'b0, r_rs1_q} - {1'b0, r_mplr_q} - {32'd0, r_cin_q};

    always_comb begin
        w_state_d = r_state_q;
        w_rs1_d   = r_rs1_q;
        w_mplr_d  = r_mplr_q;
        w_cin_d   = r_cin_q;
        w_sub_d   = r_sub_q;
        w_acc_d   = r_acc_q;
        w_cnt_d   = r_cnt_q;
        w_shamt_d = r_shamt_q;
        w_idone_d = 1'b0;
        w_wen_d   = 1'b0;
        w_wsel_d  = 1'b0;
        w_wdata_d = 32'd0;

        case (r_state_q)
            S_IDLE: begin
                if (w_accept) begin
                    w_rs1_d  = malu_rs1;
                    w_mplr_d = malu_rs2;
                    w_cin_d  = malu_rs3[0];
                    w_sub_d  = id_subclass;
                    case (id_subclass)
                        c_SUB_MADD, c_SUB_MSUB: w_state_d = S_CALC;
                        c_SUB_MMUL: begin
                            w_state_d = S_MUL;
                            w_cnt_d   = c_STEPS;
                            w_shamt_d = 6'd0;
                            w_acc_d   = {32'd0, malu_rs3};
                        end
                        // Illegal subclass: complete immediately, no write.
                        default: w_idone_d = 1'b1;
                    endcase
                end
            end
            S_CALC: begin
                if (!malu_ivalid) begin
                    w_state_d = S_IDLE;
                end else begin
                    w_acc_d   = {31'd0, (r_sub_q == c_SUB_MSUB) ? w_diff : w_sum};
                    w_state_d = S_WLO;
                end
            end
            S_MUL: begin
                if (!malu_ivalid) begin
                    w_state_d = S_IDLE;
                end else begin
                    w_acc_d   = w_mul_acc;
                    w_mplr_d  = r_mplr_q >> MUL_BPC;
                    w_shamt_d = r_shamt_q + c_BPC;
                    w_cnt_d   = r_cnt_q - 6'd1;
                    if (r_cnt_q == 6'd1) begin
                        w_state_d = S_WLO;
                    end
                end
            end
            S_WLO: begin
                if (!malu_ivalid) begin
                    w_state_d = S_IDLE;
                end else begin
                    w_wen_d   = 1'b1;
                    w_wdata_d = r_acc_q[31:0];
                    w_state_d = S_WHI;
                end
            end
            S_WHI: begin
                // Low word is already committed, so the high word always follows.
                w_wen_d   = 1'b1;
                w_wsel_d  = 1'b1;
                w_wdata_d = r_acc_q[63:32];
                w_idone_d = 1'b1;
                w_state_d = S_IDLE;
            end
            default: w_state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge g_clk) begin
        if (g_reset) begin
            r_state_q <= S_IDLE;
            r_rs1_q   <= 32'd0;
            r_mplr_q  <= 32'd0;
            r_cin_q   <= 1'b0;
            r_sub_q   <= 4'd0;
            r_acc_q   <= 64'd0;
            r_cnt_q   <= 6'd0;
            r_shamt_q <= 6'd0;
            r_idone_q <= 1'b0;
            r_wen_q   <= 1'b0;
            r_wsel_q  <= 1'b0;
            r_wdata_q <= 32'd0;
        end else begin
            r_state_q <= w_state_d;
            r_rs1_q   <= w_rs1_d;
            r_mplr_q  <= w_mplr_d;
            r_cin_q   <= w_cin_d;
            r_sub_q   <= w_sub_d;
            r_acc_q   <= w_acc_d;
            r_cnt_q   <= w_cnt_d;
            r_shamt_q <= w_shamt_d;
            r_idone_q <= w_idone_d;
            r_wen_q   <= w_wen_d;
            r_wsel_q  <= w_wsel_d;
            r_wdata_q <= w_wdata_d;
        end
    end

    assign malu_idone = r_idone_q;
    assign malu_wen   = r_wen_q;
    assign malu_wsel  = r_wsel_q;
    assign malu_wdata = r_wdata_q;
    assign malu_busy  = (r_state_q != S_IDLE);

endmodule
`default_nettype wire
